// File: rtl/wb_ram_pkg.sv
// Shared constants and FSM encoding for the Wishbone RAM arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package wb_ram_pkg;

   localparam int WB_ADDR_W = 11;
   localparam int WB_DATA_W = 32;
   localparam int WB_SEL_W  = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Round-robin priority picker: first requester after 'last', wrapping around.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is pending.
module wb_rr_pick #(
   parameter int NUM_MASTERS = 2,
   parameter int GW          = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [GW-1:0]          last,
   output logic [GW-1:0]          winner,
   output logic                   valid
);

   logic [GW-1:0] cand;

   // Scan from the farthest offset down so the nearest requester after 'last' wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         cand = GW'((int'(last) + i) % NUM_MASTERS);
         if (req[cand]) begin
            winner = cand;
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one RAM slave; owner holds the bus for its whole cyc.
// Latency: one clock from cyc to s_cyc_o; master/slave signals then pass combinationally.
// Backpressure: losers wait with cyc/stb held and see no ack; WB_RAM_ARBITER_TIMEOUT_EN adds a stall error pulse.
module wb_ram_arbiter
   import wb_ram_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int GW             = 1,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clk_i,
   input  logic                           rst_n_i,
   input  logic [NUM_MASTERS*WB_ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS*WB_DATA_W-1:0] m_data_i,
   input  logic [NUM_MASTERS-1:0]         m_we_i,
   input  logic [NUM_MASTERS-1:0]         m_cyc_i,
   input  logic [NUM_MASTERS-1:0]         m_stb_i,
   input  logic [NUM_MASTERS*WB_SEL_W-1:0]  m_sel_i,
   output logic [NUM_MASTERS-1:0]         m_ack_o,
   output logic [NUM_MASTERS-1:0]         m_err_o,
   output logic [WB_DATA_W-1:0]           m_data_o,
   output logic [WB_ADDR_W-1:0]           s_addr_o,
   output logic [WB_DATA_W-1:0]           s_data_o,
   output logic                           s_we_o,
   output logic                           s_cyc_o,
   output logic                           s_stb_o,
   output logic [WB_SEL_W-1:0]            s_sel_o,
   input  logic                           s_ack_i,
   input  logic [WB_DATA_W-1:0]           s_data_i,
   output logic [GW-1:0]                  grant_o,
   output logic                           busy_o
);

   if ((NUM_MASTERS < 2) || (NUM_MASTERS > 4) ||
       (GW != ((NUM_MASTERS > 2) ? 2 : 1)) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
      $error("wb_ram_arbiter: unsupported parameter combination");
   end

   state_t          state, state_nxt;
   logic [GW-1:0]   grant, last;
   logic [GW-1:0]   winner;
   logic            pick_vld;
   logic            busy;
   logic            sel_cyc, sel_stb, sel_we;
   logic [NUM_MASTERS-1:0] ack_vec, err_vec;

   wb_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .GW          (GW)
   ) u_pick (
      .req    (m_cyc_i),
      .last   (last),
      .winner (winner),
      .valid  (pick_vld)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= ST_IDLE;
         grant <= '0;
         last  <= GW'(NUM_MASTERS - 1);
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && pick_vld) begin
            grant <= winner;
            last  <= winner;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pick_vld) state_nxt = ST_BUSY;
         ST_BUSY: if (!sel_cyc) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef WB_RAM_ARBITER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt;
   logic          err_q;

   // Counter rests whenever the owner is acked or the bus is about to be released.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         to_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (!busy || s_ack_i || state_nxt != ST_BUSY) begin
            to_cnt <= '0;
         end else if (s_stb_o) begin
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               to_cnt <= '0;
               err_q  <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end
`endif

   always_comb begin
      busy     = (state == ST_BUSY);
      sel_cyc  = 1'b0;
      sel_stb  = 1'b0;
      sel_we   = 1'b0;
      s_addr_o = '0;
      s_data_o = '0;
      s_sel_o  = '0;
      ack_vec  = '0;
      err_vec  = '0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         if (grant == GW'(k)) begin
            sel_cyc  = m_cyc_i[k];
            sel_stb  = m_stb_i[k];
            sel_we   = m_we_i[k];
            s_addr_o = m_addr_i[k*WB_ADDR_W +: WB_ADDR_W];
            s_data_o = m_data_i[k*WB_DATA_W +: WB_DATA_W];
            s_sel_o  = m_sel_i[k*WB_SEL_W +: WB_SEL_W];
            ack_vec[k] = busy & s_ack_i;
`ifdef WB_RAM_ARBITER_TIMEOUT_EN
            err_vec[k] = busy & err_q;
`endif
         end
      end
      s_cyc_o  = busy & sel_cyc;
      s_stb_o  = busy & sel_cyc & sel_stb;
      s_we_o   = busy & sel_we;
      m_ack_o  = ack_vec;
      m_err_o  = err_vec;
      m_data_o = s_data_i;
      grant_o  = grant;
      busy_o   = busy;
   end

endmodule
